aes_block_deserializer: RTL and testbench

- Output-side counterpart of the byte-serial AES datapath core.
- Collects the 16 result bytes that the core emits one per cycle (data_out with controller strobe) and assembles them into a 128-bit block.
- Presents the block to the host over a valid/ready handshake.
- Two-stage buffering (assembly register plus output register) lets the core start streaming the next block while the host has not yet taken the previous one.

---
 rtl/aes_block_deserializer.sv | 124 ++++++++++++
 tb/tb_aes_block_deserializer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/aes_block_deserializer.sv
// Assembles the byte-serial AES result stream into a block and offers it on valid/ready.
// Optional AES_DESER_BLOCK_COUNT_EN adds a 16-bit count of handshake transfers (block_count).
module aes_block_deserializer #(
  parameter int unsigned BYTES_PER_BLOCK = 16,
  parameter int unsigned BYTE_W          = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              byte_valid,
  input  logic [BYTE_W-1:0]                 byte_in,
  input  logic                              block_start,
  input  logic                              clr_overflow,
  input  logic                              block_ready,
  output logic [BYTES_PER_BLOCK*BYTE_W-1:0] block_out,
  output logic                              block_valid,
  output logic                              busy,
`ifdef AES_DESER_BLOCK_COUNT_EN
  output logic [15:0]                       block_count,
`endif
  output logic                              overflow
);

  localparam int unsigned W    = BYTES_PER_BLOCK * BYTE_W;
  localparam int unsigned IdxW = $clog2(BYTES_PER_BLOCK);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BYTES_PER_BLOCK - 1);

  logic [IdxW-1:0] idx_q, idx_d, idx_base;
  logic [W-1:0]    asm_q, asm_d, asm_next;
  logic [W-1:0]    out_q, out_d;
  logic            valid_q, valid_d;
  logic            pending_q, pending_d;
  logic            overflow_q, overflow_d;
  logic            accept, complete, xfer, out_free;

  always_comb begin
    idx_base = block_start ? '0 : idx_q;
    // Assembly with the current byte merged in; lets the last byte bypass straight to the output.
    asm_next = asm_q;
    for (int k = 0; k < int'(BYTES_PER_BLOCK); k++) begin
      if (idx_base == IdxW'(k)) asm_next[W-1-k*BYTE_W -: BYTE_W] = byte_in;
    end

    accept   = byte_valid & ~pending_q;
    complete = accept & ~block_start & (idx_q == LastIdx);
    xfer     = valid_q & block_ready;
    out_free = ~valid_q | block_ready;

    idx_d      = idx_q;
    asm_d      = asm_q;
    out_d      = out_q;
    valid_d    = valid_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;

    if (accept) begin
      asm_d = asm_next;
      idx_d = (idx_base == LastIdx) ? '0 : idx_base + IdxW'(1);
    end else if (block_start) begin
      idx_d = '0;
    end

    if (xfer) valid_d = 1'b0;

    // A pending block only exists while the output register is occupied.
    if (pending_q && xfer) begin
      out_d     = asm_q;
      valid_d   = 1'b1;
      pending_d = 1'b0;
    end

    if (complete) begin
      if (out_free) begin
        out_d   = asm_next;
        valid_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    if (byte_valid && pending_q) overflow_d = 1'b1;
    else if (clr_overflow)       overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q      <= '0;
      asm_q      <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef AES_DESER_BLOCK_COUNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_overflow) count_d = xfer ? 16'd1 : 16'd0;
    else if (xfer)    count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign block_count = count_q;
`endif

  assign block_out   = out_q;
  assign block_valid = valid_q;
  assign busy        = (idx_q != '0) | pending_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_aes_block_deserializer.sv
// Directed self-checking bench for aes_block_deserializer (default 16 x 8-bit configuration).
module tb_aes_block_deserializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         byte_valid, block_start, clr_overflow, block_ready;
  logic [7:0]   byte_in;
  logic [127:0] block_out;
  logic         block_valid, busy, overflow;
`ifdef AES_DESER_BLOCK_COUNT_EN
  logic [15:0]  block_count;
`endif

  int checks   = 0;
  int failures = 0;

  aes_block_deserializer #(
    .BYTES_PER_BLOCK(16),
    .BYTE_W         (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_valid  (byte_valid),
    .byte_in     (byte_in),
    .block_start (block_start),
    .clr_overflow(clr_overflow),
    .block_ready (block_ready),
    .block_out   (block_out),
    .block_valid (block_valid),
    .busy        (busy),
`ifdef AES_DESER_BLOCK_COUNT_EN
    .block_count (block_count),
`endif
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present one byte for a single clock edge; returns 1 time unit after that edge.
  task automatic send(input logic [7:0] b, input logic st);
    byte_valid  = 1'b1;
    byte_in     = b;
    block_start = st;
    @(posedge clk);
    #1;
    byte_valid  = 1'b0;
    block_start = 1'b0;
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic stream(input logic [7:0] first, input logic [7:0] step, input int n);
    logic [7:0] b;
    b = first;
    for (int i = 0; i < n; i++) begin
      send(b, 1'b0);
      b = b + step;
    end
  endtask

  initial begin
    rst          = 1'b0;
    byte_valid   = 1'b0;
    byte_in      = 8'h00;
    block_start  = 1'b0;
    clr_overflow = 1'b0;
    block_ready  = 1'b1;
    #12;
    check("rst_valid", {127'b0, block_valid}, 128'd0);
    check("rst_busy", {127'b0, busy}, 128'd0);
    check("rst_ovf", {127'b0, overflow}, 128'd0);
    check("rst_out", block_out, 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single block with the host always ready
    send(8'h00, 1'b0);
    check("single_busy_mid", {127'b0, busy}, 128'd1);
    stream(8'h01, 8'h01, 15);
    check("single_valid", {127'b0, block_valid}, 128'd1);
    check("single_out", block_out, 128'h000102030405060708090A0B0C0D0E0F);
    check("single_busy_done", {127'b0, busy}, 128'd0);
    idle(1);
    check("single_valid_drop", {127'b0, block_valid}, 128'd0);

    // Backpressure: A sits in the output register, B goes pending
    block_ready = 1'b0;
    stream(8'hAA, 8'h00, 16);
    check("bp_a_valid", {127'b0, block_valid}, 128'd1);
    stream(8'hBB, 8'h00, 16);
    check("bp_a_held", block_out, {16{8'hAA}});
    check("bp_pending_busy", {127'b0, busy}, 128'd1);
    send(8'h55, 1'b0);
    check("ovf_set", {127'b0, overflow}, 128'd1);
    clr_overflow = 1'b1;
    send(8'h56, 1'b0);
    check("ovf_drop_beats_clr", {127'b0, overflow}, 128'd1);
    idle(1);
    clr_overflow = 1'b0;
    check("ovf_cleared", {127'b0, overflow}, 128'd0);
    check("bp_a_stable", block_out, {16{8'hAA}});
    block_ready = 1'b1;
    idle(1);
    block_ready = 1'b0;
    check("bp_b_out", block_out, {16{8'hBB}});
    check("bp_b_valid", {127'b0, block_valid}, 128'd1);
    check("bp_busy_clear", {127'b0, busy}, 128'd0);
    idle(2);
    check("bp_b_stable", block_out, {16{8'hBB}});
    block_ready = 1'b1;
    idle(1);
    check("bp_final_drop", {127'b0, block_valid}, 128'd0);

    // Restart discards a partial assembly
    stream(8'h11, 8'h00, 5);
    send(8'h22, 1'b1);
    check("restart_busy", {127'b0, busy}, 128'd1);
    stream(8'h33, 8'h00, 14);
    check("restart_no_early", {127'b0, block_valid}, 128'd0);
    send(8'h33, 1'b0);
    check("restart_valid", {127'b0, block_valid}, 128'd1);
    check("restart_out", block_out, {8'h22, {15{8'h33}}});
    idle(1);

    // block_start on what would be the completing byte wins
    stream(8'h44, 8'h00, 15);
    send(8'h66, 1'b1);
    check("start_wins_valid", {127'b0, block_valid}, 128'd0);
    check("start_wins_busy", {127'b0, busy}, 128'd1);
    stream(8'h77, 8'h00, 15);
    check("start_wins_out", block_out, {8'h66, {15{8'h77}}});
    idle(1);

    // Asynchronous reset between edges while a block is held and another is partial
    block_ready = 1'b0;
    stream(8'hC3, 8'h00, 16);
    stream(8'h99, 8'h00, 7);
    check("prereset_valid", {127'b0, block_valid}, 128'd1);
    #2;
    rst = 1'b0;
    #1;
    check("areset_valid", {127'b0, block_valid}, 128'd0);
    check("areset_busy", {127'b0, busy}, 128'd0);
    check("areset_out", block_out, 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    block_ready = 1'b1;
    stream(8'h80, 8'h01, 16);
    check("post_reset_out", block_out, 128'h808182838485868788898A8B8C8D8E8F);
    check("post_reset_valid", {127'b0, block_valid}, 128'd1);

`ifdef AES_DESER_BLOCK_COUNT_EN
    // Clear coinciding with a transfer leaves a count of one
    clr_overflow = 1'b1;
    idle(1);
    clr_overflow = 1'b0;
    check("cnt_clr_xfer", {112'b0, block_count}, 128'd1);
    stream(8'h01, 8'h00, 16);
    stream(8'h02, 8'h00, 16);
    idle(1);
    check("cnt_three", {112'b0, block_count}, 128'd3);
`else
    idle(1);
`endif
    check("end_idle", {127'b0, block_valid}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
